// File: rtl/pipe_stage_buf_pkg.sv
// Purpose: shared pipeline-stage types and payload widths for the pipe_stage_buf slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int INSTR_W = 16;   // instruction word
    localparam int ID_RR_W = 19;   // ID->RR stage payload
    localparam int RR_EX_W = 42;   // RR->EX stage payload

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

    // Occupancy class of a buffer holding cnt of depth entries.
    function automatic occ_state_t occ_of(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return EMPTY;
        else if (cnt >= depth)
            return FULL;
        else
            return PARTIAL;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Purpose: upstream + downstream valid/ready handshake bundle of one pipeline-stage buffer.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the producer, out_ready throttles the buffer.
// Ports: in_valid/in_data/in_ready (upstream side), out_valid/out_data/out_ready (downstream side).
// master = the stages around the buffer, slave = the buffer itself.
interface pipe_stage_buf_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_buf_wrap_ctr.sv
// Purpose: modulo-DEPTH pointer counter (wraps DEPTH-1 -> 0) with increment and clear.
// Latency: pointer moves on the clock edge after inc/clr.
// Backpressure: none; caller qualifies inc.
// Ports: clk, rst (sync active-high), clr (sync kill), inc, ptr.
module pipe_wrap_ctr #(
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Purpose: elastic DEPTH x WIDTH pipeline-stage buffer with valid/ready on both sides and flush.
// Latency: 1 cycle in->out; 0 cycles from empty when PIPE_STAGE_BYPASS_EN is defined.
// Backpressure: in_ready drops when full (no same-cycle refill on pop) and during flush/reset.
// Ports: clk, resetn (sync, active-high), flush, bus (pipe_stage_buf_if.slave), count.
// Optional feature macro: PIPE_STAGE_BYPASS_EN (empty-buffer combinational pass-through).
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    pipe_stage_buf_if.slave   bus,
    output logic [CW-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    occ_state_t       occ;
    logic             push;
    logic             pop;
    logic             byp;      // empty-buffer pass-through active this cycle
    logic             wr_en;    // entry actually stored
    logic             rd_en;    // stored entry actually retired

    always_comb begin
        occ          = occ_of(32'(count), DEPTH);
        bus.in_ready = (occ != FULL) & ~flush & ~resetn;
        push         = bus.in_valid & bus.in_ready;
        byp          = 1'b0;
`ifdef PIPE_STAGE_BYPASS_EN
        byp          = (occ == EMPTY) & bus.in_valid & ~flush & ~resetn;
`endif
        bus.out_valid = ((occ != EMPTY) | byp) & ~resetn;
        pop           = bus.out_valid & bus.out_ready;
        bus.out_data  = '0;
        if (bus.out_valid)
            bus.out_data = byp ? bus.in_data : mem[rd_ptr];
        // A bypassed item taken downstream in the same cycle is never stored,
        // and it is not a stored entry, so rd_ptr must not move for it.
        wr_en = push & ~(byp & bus.out_ready);
        rd_en = pop & ~byp;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= bus.in_data;
    end

    // A pop in the flush cycle still completes downstream; the clear wins.
    always_ff @(posedge clk) begin
        if (resetn || flush)
            count <= '0;
        else if (wr_en && !rd_en)
            count <= count + 1'b1;
        else if (rd_en && !wr_en)
            count <= count - 1'b1;
    end

    pipe_wrap_ctr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ctr (
        .clk (clk),
        .rst (resetn),
        .clr (flush),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    pipe_wrap_ctr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ctr (
        .clk (clk),
        .rst (resetn),
        .clr (flush),
        .inc (rd_en),
        .ptr (rd_ptr)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Purpose: directed self-checking bench for pipe_stage_buf (DEPTH=2 and DEPTH=3 instances).
// Latency: stimulus changes 1 time unit after each rising edge; monitor samples on falling edge.
// Backpressure: scoreboard follows the DUT handshakes, so any latency/stall pattern is tolerated.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        sel;          // 0: DEPTH=2 instance, 1: DEPTH=3 instance
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic [1:0]  cnt_a, cnt_b;
    logic        o_in_ready, o_out_valid;
    logic [15:0] o_out_data;
    logic [1:0]  o_count;

    int tests = 0;
    int fails = 0;
    int npop  = 0;
    logic last_push;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.WIDTH(16)) ifa ();
    pipe_stage_buf_if #(.WIDTH(16)) ifb ();

    assign ifa.in_valid  = in_valid & ~sel;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready & ~sel;
    assign ifb.in_valid  = in_valid & sel;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready & sel;

    assign o_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
    assign o_out_valid = sel ? ifb.out_valid : ifa.out_valid;
    assign o_out_data  = sel ? ifb.out_data  : ifa.out_data;
    assign o_count     = sel ? cnt_b         : cnt_a;

    pipe_stage_buf #(.WIDTH(16), .DEPTH(2)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (ifa),
        .count  (cnt_a)
    );

    pipe_stage_buf #(.WIDTH(16), .DEPTH(3)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (ifb),
        .count  (cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: record the handshakes that will fire on the coming edge.
    task automatic step();
        logic [15:0] exp_d;
        @(negedge clk);
        last_push = 1'b0;
        if (resetn) begin
            sb.delete();
        end else begin
            if (in_valid && o_in_ready) begin
                sb.push_back(in_data);
                last_push = 1'b1;
            end
            if (o_out_valid && out_ready) begin
                npop++;
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL pop_unexpected: observed %0h expected no output", o_out_data);
                end
                if (sb.size() != 0) begin
                    exp_d = sb.pop_front();
                    chk("pop_data", 32'(o_out_data), 32'(exp_d));
                end
            end
            if (flush)
                sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int maxc;
        int nxt;

        sel       = 1'b0;
        resetn    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        out_ready = 1'b1;
        #1;

        // Reset held with in_valid asserted
        repeat (3) step();
        chk("rst_in_ready",  32'(o_in_ready),  32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_count",     32'(o_count),     32'd0);
        chk("rst_out_data",  32'(o_out_data),  32'd0);
        resetn   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(o_in_ready), 32'd1);

        // Streaming 0x1111..0x1118 with out_ready high
        base     = npop;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h1111 + 16'(i);
            step();
            chk("stream_cnt_le1", 32'(o_count <= 2'd1), 32'd1);
            if (i == 0) begin
                chk("stream_lat_valid", 32'(o_out_valid), 32'd1);
                chk("stream_lat_data",  32'(o_out_data),  32'h1111);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6 && sb.size() != 0; i++) step();
        chk("stream_drained", 32'(sb.size()), 32'd0);
        chk("stream_delivered", 32'(npop - base), 32'd8);

        // Stall fills the buffer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hA001;
        step();
        in_data   = 16'hA002;
        step();
        in_valid  = 1'b0;
        #1;
        chk("stall_count",     32'(o_count),     32'd2);
        chk("stall_in_ready",  32'(o_in_ready),  32'd0);
        chk("stall_out_data",  32'(o_out_data),  32'hA001);
        out_ready = 1'b1;
        step();
        chk("unstall_count",    32'(o_count),    32'd1);
        chk("unstall_in_ready", 32'(o_in_ready), 32'd1);
        chk("unstall_data",     32'(o_out_data), 32'hA002);
        step();
        chk("unstall_empty", 32'(o_out_valid), 32'd0);

        // Simultaneous push and pop at count=1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC001;
        step();
        out_ready = 1'b1;
        in_data   = 16'hC002;
        step();
        in_valid  = 1'b0;
        #1;
        chk("pp_count", 32'(o_count),    32'd1);
        chk("pp_data",  32'(o_out_data), 32'hC002);
        step();
        chk("pp_drained", 32'(o_count), 32'd0);

        // Flush at count=2 while 0xBEEF is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hD001;
        step();
        in_data   = 16'hD002;
        step();
        flush     = 1'b1;
        in_data   = 16'hBEEF;
        #1;
        chk("flush_in_ready", 32'(o_in_ready), 32'd0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("flush_count",     32'(o_count),     32'd0);
        chk("flush_out_valid", 32'(o_out_valid), 32'd0);
        base      = npop;
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_no_output", 32'(npop - base), 32'd0);

        // Mid-operation reset drops held data
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hE001;
        step();
        in_valid  = 1'b0;
        resetn    = 1'b1;
        step();
        resetn    = 1'b0;
        #1;
        chk("midrst_count",     32'(o_count),     32'd0);
        chk("midrst_out_valid", 32'(o_out_valid), 32'd0);

        // DEPTH=3: 7 items through the buffer with periodic stalls (pointer wrap)
        sel  = 1'b1;
        base = npop;
        maxc = 0;
        nxt  = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid  = (nxt < 7);
            in_data   = 16'h5000 + 16'(nxt);
            out_ready = (c % 4 == 3);
            step();
            if (last_push) nxt++;
            if (int'(o_count) > maxc) maxc = int'(o_count);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() != 0; i++) step();
        chk("wrap_pushed",    32'(nxt),        32'd7);
        chk("wrap_delivered", 32'(npop - base), 32'd7);
        chk("wrap_max_count", 32'(maxc),       32'd3);
        chk("wrap_drained",   32'(sb.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage buffer for the IITB RISC pipeline. It is the successor to the fixed, always-loading inter-stage register. It holds up to DEPTH entries of WIDTH bits and adds valid/ready handshakes on both sides, stall absorption and a synchronous flush. It sits between any two pipeline stages (IF→ID, ID→RR, RR→EX, EX→MA, MA→WB), so back-pressure from a stalled stage propagates without data loss.

## Interface
- WIDTH, 16: payload width in bits (≥1).
- DEPTH, 2: number of entries (1..8; need not be a power of two).
- CW, $clog2(DEPTH+1): occupancy counter width (derived; do not override).
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-high reset (1 = reset).
- flush  input  1  synchronous kill of all held entries (branch/jump squash).
- in_valid  input  1  upstream stage presents in_data.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  buffer accepts in_data this cycle.
- out_valid  output  1  out_data holds a valid entry.
- out_data  output  WIDTH  oldest entry.
- out_ready  input  1  downstream consumes out_data this cycle.
- count  output  CW  current number of held entries.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage is a DEPTH-entry circular array with wr_ptr, rd_ptr (0..DEPTH-1) and count (0..DEPTH).
- Occupancy state is derived from count: EMPTY (0), PARTIAL, FULL (DEPTH).
- in_ready = (count != DEPTH) & ~flush & ~resetn. When FULL, in_ready is 0 even if out_ready is 1, so there is no same-cycle refill path.
- out_valid = (count != 0) & ~resetn. out_data = mem[rd_ptr] when out_valid, else all-zero.
- On push: mem[wr_ptr] ← in_data. wr_ptr wraps DEPTH-1 → 0.
- On pop: rd_ptr wraps DEPTH-1 → 0.
- count updates: +1 on push-only, −1 on pop-only, unchanged on push & pop together.
- flush has priority over everything: next cycle count=0 and wr_ptr=rd_ptr=0. Any pop presented in the flush cycle still completes downstream, but the entry is discarded.
- resetn has priority over flush and gives the same state result.
- Entries are delivered in strict FIFO order with no duplication or loss absent flush.

## Timing
- Reset values, held while resetn=1: count=0, pointers=0, in_ready=0, out_valid=0, out_data=0.
- The first push is possible in the first cycle after resetn falls.
- Latency: a push in cycle N appears on out_valid/out_data in cycle N+1 (see Configuration for the bypass case).
- Throughput: 1 entry/cycle sustained whenever 0 < count < DEPTH, or count = DEPTH−1 with simultaneous push & pop.
- A stall (out_ready=0) fills the buffer. in_ready falls in the cycle after count reaches DEPTH.
- Mid-operation reset or flush: held data is lost. The upstream stage re-issues.

## Configuration
- PIPE_STAGE_BYPASS_EN defined:
  - When count=0, in_valid=1 and ~flush, out_valid=1 and out_data=in_data combinationally.
  - If out_ready=1 in that cycle, the item is consumed without being written (zero latency) and count stays 0.
  - If out_ready=0, the item is written normally.
- PIPE_STAGE_BYPASS_EN undefined: 1-cycle latency always, with no combinational path from in_* to out_*.

## Structure
- Shared package pipe_pkg:
  - INSTR_W=16 and stage payload width constants: ID_RR_W=19, RR_EX_W=42.
  - typedef occ_state_t {EMPTY, PARTIAL, FULL}.
- One sub-module, pipe_wrap_ctr: a modulo-DEPTH pointer counter with inc and clr inputs, instantiated twice (wr_ptr, rd_ptr).

## Test plan
- Reset: hold resetn=1 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, count=0, out_data=0. The cycle after release, in_ready=1.
- Streaming, WIDTH=16, DEPTH=2, out_ready=1, push 0x1111..0x1118 back-to-back → outputs appear in order one cycle later each (same cycle with bypass), with count ≤1.
- Stall: out_ready=0, push 0xA001, 0xA002 → count=2, in_ready=0, out_data=0xA001. Raise out_ready → 0xA001 then 0xA002, and in_ready returns to 1 after the first pop.
- Wrap, DEPTH=3: push/pop 7 items with alternating stalls → FIFO order is preserved across pointer wrap 2→0, and count never exceeds 3.
- Flush: count=2 with flush=1 and in_valid=1 (0xBEEF) → next cycle count=0, out_valid=0, and 0xBEEF is never output.
- Simultaneous push & pop at count=1 → count stays 1 and out_data advances to the next item.
